fetch_queue: RTL and testbench

//   Parametrised instruction fetch queue between ifu and if_id in the pipelined RV32 core.

---
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between ifu and if_id: circular buffer of {pc, instr} pairs.
// Latency: 1 cycle push-to-head; 0 cycles through the optional bypass when empty.
// Backpressure: in_ready = !full from registered occupancy; out_* hold while out_ready is low.
module fetch_queue #(
  parameter int                 XLEN     = 32,
  parameter int                 DEPTH    = 4,
  parameter int                 BYPASS   = 0,
  parameter logic [XLEN-1:0]    NOP_INST = XLEN'(32'h0000_0013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_flag,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic           empty;
  logic           full;
  logic           byp_sel;
  logic           push;
  logic           pop;
  entry_t         head;

  assign count = count_q;
  assign head  = mem[rd_ptr];

  // Handshake decode and output muxing; the bypass path only exists while empty.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    byp_sel   = (BYPASS != 0) && empty;
    in_ready  = rst && !full;
    out_valid = rst && !flush_flag && (!empty || (byp_sel && in_valid));
    // A bypassed word consumed this cycle never enters storage.
    pop       = out_valid && out_ready && !empty;
    push      = in_valid && in_ready && !flush_flag && !(byp_sel && out_ready);
    out_pc    = '0;
    out_instr = NOP_INST;
    if (out_valid) begin
      if (empty) begin
        out_pc    = in_pc;
        out_instr = in_instr;
      end else begin
        out_pc    = head.pc;
        out_instr = head.instr;
      end
    end
  end

  // Pointer and occupancy state; reset beats flush, flush discards any push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_flag) begin
      rd_ptr  <= wr_ptr;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage is deliberately left unreset; push already implies rst is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: one BYPASS=0 and one BYPASS=1 instance share stimulus.
// Each is compared every cycle against a list-based occupancy model.
// Directed phases follow the queue's key scenarios, then randomized traffic.
module tb_fetch_queue;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush_flag, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_pc0, out_instr0, out_pc1, out_instr1;
  logic [2:0]  count0, count1;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BYPASS(0)) dut (
    .clk(clk), .rst(rst), .flush_flag(flush_flag),
    .in_valid(in_valid), .in_ready(in_ready0), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0),
    .out_instr(out_instr0), .count(count0));

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .flush_flag(flush_flag),
    .in_valid(in_valid), .in_ready(in_ready1), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1),
    .out_instr(out_instr1), .count(count1));

  int checks = 0;
  int errors = 0;

  // Model: per-instance ordered list, element 0 is the oldest entry.
  logic [63:0] mq [2][DEPTH];
  int          msize [2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_model(input int i, input bit byp, input logic ir, input logic ov,
                            input logic [31:0] op, input logic [31:0] oi, input logic [2:0] cnt);
    logic        e_rdy, e_vld, served, do_pop, do_push;
    logic [31:0] e_pc, e_instr;
    e_rdy   = rst && (msize[i] < DEPTH);
    e_vld   = 1'b0;
    e_pc    = 32'h0;
    e_instr = NOP;
    if (rst && !flush_flag) begin
      if (msize[i] > 0) begin
        e_vld   = 1'b1;
        e_pc    = mq[i][0][63:32];
        e_instr = mq[i][0][31:0];
      end else if (byp && in_valid) begin
        e_vld   = 1'b1;
        e_pc    = in_pc;
        e_instr = in_instr;
      end
    end
    check_val($sformatf("d%0d in_ready", i), ir, e_rdy);
    check_val($sformatf("d%0d out_valid", i), ov, e_vld);
    check_val($sformatf("d%0d out_pc", i), op, e_pc);
    check_val($sformatf("d%0d out_instr", i), oi, e_instr);
    check_val($sformatf("d%0d count", i), cnt, msize[i]);
    // Advance the model to the state after the coming edge.
    if (!rst || flush_flag) begin
      msize[i] = 0;
    end else begin
      served  = (msize[i] == 0) && byp && in_valid && out_ready;
      do_pop  = (msize[i] > 0) && out_ready;
      do_push = in_valid && (msize[i] < DEPTH) && !served;
      if (do_pop) begin
        for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
        msize[i]--;
      end
      if (do_push) begin
        mq[i][msize[i]] = {in_pc, in_instr};
        msize[i]++;
      end
    end
  endtask

  // One clock: compare both instances mid-cycle, then move past the edge.
  task automatic cycle();
    @(negedge clk);
    step_model(0, 1'b0, in_ready0, out_valid0, out_pc0, out_instr0, count0);
    step_model(1, 1'b1, in_ready1, out_valid1, out_pc1, out_instr1, count1);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pc_run;

  initial begin
    msize[0] = 0;
    msize[1] = 0;
    rst = 1'b0; flush_flag = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 32'h0; in_instr = 32'h0000_0013;

    // Reset held for 3 clocks with in_valid high.
    repeat (3) cycle();
    check_val("rst count", count0, 0);
    check_val("rst in_ready", in_ready0, 0);
    check_val("rst out_valid", out_valid0, 0);
    check_val("rst out_instr", out_instr0, 32'h0000_0013);

    // Fill to DEPTH with decode stalled.
    rst = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = k * 4; in_instr = $urandom;
      cycle();
    end
    check_val("fill count", count0, 4);
    check_val("fill in_ready", in_ready0, 0);
    check_val("fill count byp", count1, 4);
    in_pc = 32'h10; in_instr = $urandom;
    repeat (2) cycle();
    check_val("held 5th count", count0, 4);
    out_ready = 1'b1;
    cycle();
    check_val("pop while full", count0, 3);
    out_ready = 1'b0;
    cycle();
    check_val("5th accepted", count0, 4);
    check_val("head after pop", out_pc0, 32'h4);

    // Full + flush + pop empties without delivery.
    flush_flag = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    cycle();
    flush_flag = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_val("full flush count", count0, 0);
    check_val("full flush out_valid", out_valid0, 0);
    check_val("full flush count byp", count1, 0);

    // Alternate push/pop over 10 words so the pointers wrap twice.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; out_ready = 1'b0; in_pc = k * 4; in_instr = $urandom;
      cycle();
      in_valid = 1'b0; out_ready = 1'b1;
      check_val($sformatf("wrap out_pc %0d", k), out_pc0, k * 4);
      cycle();
    end

    // Stall with two entries queued.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200; in_instr = $urandom;
    cycle();
    in_pc = 32'h204; in_instr = $urandom;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_val("stall count", count0, 2);
      check_val("stall out_pc", out_pc0, 32'h200);
    end

    // Flush with three queued while a fetch is offered.
    in_valid = 1'b1; in_pc = 32'h208; in_instr = $urandom;
    cycle();
    check_val("pre-flush count", count0, 3);
    flush_flag = 1'b1; in_pc = 32'h40; in_instr = $urandom;
    cycle();
    flush_flag = 1'b0; in_pc = 32'h80; in_instr = $urandom;
    check_val("flush count", count0, 0);
    check_val("flush out_valid", out_valid0, 0);
    cycle();
    in_valid = 1'b0;
    check_val("post-flush out_pc", out_pc0, 32'h80);
    check_val("post-flush out_valid", out_valid0, 1);

    // Same-cycle bypass on an empty queue.
    flush_flag = 1'b1;
    cycle();
    flush_flag = 1'b0;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = $urandom; out_ready = 1'b1;
    #1;
    check_val("byp out_valid", out_valid1, 1);
    check_val("byp out_pc", out_pc1, 32'h100);
    check_val("nobyp out_valid", out_valid0, 0);
    cycle();
    check_val("byp count", count1, 0);
    check_val("nobyp count", count0, 1);
    in_valid = 1'b0;
    cycle();

    // Randomized traffic with occasional flush and reset.
    pc_run = 32'h1000;
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 99) != 0);
      flush_flag = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      out_ready  = $urandom_range(0, 1) != 0;
      pc_run     = pc_run + 32'h4;
      in_pc      = pc_run;
      in_instr   = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
